multicycle_control: RTL

- Next-generation MIPS control unit: multicycle FSM replacing the single-cycle combinational decoder.
- Sequences fetch, decode, execute, memory and writeback for R-type, lw, sw, beq, ori and j.
- Supports an optional memory-ready handshake, flags illegal opcodes, and keeps a retired-instruction counter.
- Sits between the instruction register opcode field and the multicycle datapath muxes/enables.

---
 rtl/cpu_ctrl_pkg.sv | 59 +++++
 rtl/opcode_decode.sv | 36 +++
 rtl/multicycle_control.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, ALU ops,
// mux selects, FSM states and the bundled control-word type.
package cpu_ctrl_pkg;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_J   = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b110;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_SHIMM = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_ORIEX  = 4'd9,
        S_ORIWB  = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
        logic       r_type;
        logic       illegal;
        logic       done;
    } ctrl_t;

endpackage

// File: rtl/opcode_decode.sv
// One-hot opcode classifier feeding the DECODE and MEMADR branch decisions.
module opcode_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic [OP_W-1:0] op,
    output logic            is_r,
    output logic            is_lw,
    output logic            is_sw,
    output logic            is_beq,
    output logic            is_ori,
    output logic            is_j,
    output logic            is_illegal
);

    always_comb begin
        is_r       = 1'b0;
        is_lw      = 1'b0;
        is_sw      = 1'b0;
        is_beq     = 1'b0;
        is_ori     = 1'b0;
        is_j       = 1'b0;
        is_illegal = 1'b0;
        case (op)
            OP_W'(OP_R):   is_r   = 1'b1;
            OP_W'(OP_LW):  is_lw  = 1'b1;
            OP_W'(OP_SW):  is_sw  = 1'b1;
            OP_W'(OP_BEQ): is_beq = 1'b1;
            OP_W'(OP_ORI): is_ori = 1'b1;
            OP_W'(OP_J):   is_j   = 1'b1;
            default:       is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// with optional memory-ready stalls, illegal-opcode flag and retire counter.
module multicycle_control
    import cpu_ctrl_pkg::*;
#(
    parameter int OP_W          = 6,
    parameter int ALUOP_W       = 3,
    parameter int USE_MEM_READY = 1,
    parameter int CNT_W         = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OP_W-1:0]    op,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSource,
    output logic [ALUOP_W-1:0] ALU_op,
    output logic               R_type,
    output logic               illegal_op,
    output logic               instr_done,
    output logic [CNT_W-1:0]   instret,
    output logic [3:0]         state
);

    state_t state_q, state_d;
    ctrl_t  c, g;
    logic   ready;
    logic   is_r, is_lw, is_sw, is_beq, is_ori, is_j, is_illegal;

    opcode_decode #(.OP_W(OP_W)) u_dec (
        .op         (op),
        .is_r       (is_r),
        .is_lw      (is_lw),
        .is_sw      (is_sw),
        .is_beq     (is_beq),
        .is_ori     (is_ori),
        .is_j       (is_j),
        .is_illegal (is_illegal)
    );

    assign ready = (USE_MEM_READY != 0) ? mem_ready : 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            instret <= '0;
        end else begin
            state_q <= state_d;
            if (c.done) instret <= instret + CNT_W'(1);
        end
    end

    always_comb begin
        c       = '0;
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALU_ADD;
                c.pc_source = PCSRC_ALU;
                c.ir_write  = ready;
                c.pc_write  = ready;
                if (ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                c.alu_src_b = SRCB_SHIMM;
                c.alu_op    = ALU_ADD;
                if (is_lw || is_sw)  state_d = S_MEMADR;
                else if (is_r)       state_d = S_EXEC;
                else if (is_beq)     state_d = S_BRANCH;
                else if (is_ori)     state_d = S_ORIEX;
                else if (is_j)       state_d = S_JUMP;
                else begin
                    c.illegal = is_illegal;
                    state_d   = S_FETCH;
                end
            end
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_ADD;
                if (is_lw)      state_d = S_MEMRD;
                else if (is_sw) state_d = S_MEMWR;
                else            state_d = S_FETCH;
            end
            S_MEMRD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
                if (ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.done       = 1'b1;
                state_d      = S_FETCH;
            end
            // store retires on the same cycle its write is accepted
            S_MEMWR: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
                if (ready) begin
                    c.done  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_B;
                c.r_type    = 1'b1;
                state_d     = S_RWB;
            end
            S_RWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
                c.done      = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = SRCB_B;
                c.alu_op        = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCSRC_ALUOUT;
                c.done          = 1'b1;
                state_d         = S_FETCH;
            end
            S_ORIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_OR;
                state_d     = S_ORIWB;
            end
            S_ORIWB: begin
                c.reg_write = 1'b1;
                c.done      = 1'b1;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCSRC_JUMP;
                c.done      = 1'b1;
                state_d     = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Reset gates every control output combinationally so the abandoned
    // instruction cannot write anything during the reset cycle itself.
    assign g = rst_n ? c : '0;

    assign PCWrite     = g.pc_write;
    assign PCWriteCond = g.pc_write_cond;
    assign IorD        = g.i_or_d;
    assign MemRead     = g.mem_read;
    assign MemWrite    = g.mem_write;
    assign IRWrite     = g.ir_write;
    assign MemtoReg    = g.mem_to_reg;
    assign RegDst      = g.reg_dst;
    assign RegWrite    = g.reg_write;
    assign ALUSrcA     = g.alu_src_a;
    assign ALUSrcB     = g.alu_src_b;
    assign PCSource    = g.pc_source;
    assign ALU_op      = ALUOP_W'(g.alu_op);
    assign R_type      = g.r_type;
    assign illegal_op  = g.illegal;
    assign instr_done  = g.done;
    assign state       = state_q;

endmodule
